// File: rtl/iir_cascade_sequencer.sv
// Purpose: time-multiplexed cascade of NSEC biquad sections sharing one 11x12 multiplier and one accumulator.
// Latency: y_valid pulses in the cycle after edge E+6*NSEC for a sample accepted at edge E.
// Backpressure: x_ready is low while a sample is in flight; peak rate is one sample per 6*NSEC+1 cycles.
module iir_cascade_sequencer #(
    parameter int NSEC = 2,
    parameter int DW   = 11,
    parameter int CW   = 12,
    parameter int AW   = $clog2(5*NSEC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] x,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic signed [DW-1:0] y,
    output logic                 y_valid,
    input  logic                 flush,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [CW-1:0] cfg_data,
    output logic                 cfg_ready,
    output logic                 busy
);
    localparam int NCOEF = 5*NSEC;
    localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int PW    = DW + CW;   // product and accumulator width
    localparam int FB    = 10;        // fractional bits of the coefficients
    localparam int RW    = DW + FB;   // accumulator bits that feed the rounded result

    // Power-up coefficients; ma1/ma2 are stored already negated so the datapath only adds.
    localparam logic signed [CW-1:0] DEF_B0  = CW'(47);
    localparam logic signed [CW-1:0] DEF_B1  = CW'(-14);
    localparam logic signed [CW-1:0] DEF_B2  = CW'(47);
    localparam logic signed [CW-1:0] DEF_MA1 = CW'(1544);
    localparam logic signed [CW-1:0] DEF_MA2 = CW'(-881);

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                 state;
    logic [2:0]             tap;
    logic [SW-1:0]          sec;
    logic [AW-1:0]          caddr;     // tracks sec*5+tap, so no multiply is needed for the bank address
    logic signed [PW-1:0]   acc;
    logic signed [DW-1:0]   xin;       // input to the section currently being computed

    logic signed [CW-1:0]   coef [NCOEF];
    logic signed [DW-1:0]   x1 [NSEC];
    logic signed [DW-1:0]   x2 [NSEC];
    logic signed [DW-1:0]   y1 [NSEC];
    logic signed [DW-1:0]   y2 [NSEC];

    logic signed [DW-1:0]   dsel;
    logic signed [CW-1:0]   csel;
    logic signed [PW-1:0]   prod;
    logic [RW-1:0]          r;
    logic signed [DW-1:0]   yo;
    logic                   unused_bits;

    assign x_ready   = (state == IDLE) && !flush;
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Select the history operand for the current tap.
    always_comb begin
        dsel = xin;
        case (tap)
            3'd0:    dsel = xin;
            3'd1:    dsel = x1[sec];
            3'd2:    dsel = x2[sec];
            3'd3:    dsel = y1[sec];
            default: dsel = y2[sec];
        endcase
    end

    assign csel = coef[caddr];
    assign prod = PW'(dsel) * PW'(csel);

    // Round half up on the low RW bits; the top accumulator bits are deliberately dropped (wrapping, no saturation).
    assign r  = acc[RW-1:0] + RW'(1 << (FB-1));
    assign yo = r[RW-1:FB];

    assign unused_bits = ^{acc[PW-1:RW], r[FB-1:0]};

    // Sequencer FSM with the accumulator, section input and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tap     <= '0;
            sec     <= '0;
            caddr   <= '0;
            acc     <= '0;
            xin     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (flush) begin
                state <= IDLE;
                tap   <= '0;
                sec   <= '0;
                caddr <= '0;
                acc   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (x_valid) begin
                            xin   <= x;
                            sec   <= '0;
                            tap   <= '0;
                            caddr <= '0;
                            state <= MAC;
                        end
                    end
                    MAC: begin
                        acc   <= ((tap == 3'd0) ? '0 : acc) + prod;
                        caddr <= caddr + AW'(1);
                        if (tap == 3'd4) begin
                            tap   <= '0;
                            state <= ROUND;
                        end else begin
                            tap <= tap + 3'd1;
                        end
                    end
                    ROUND: begin
                        if (sec == SW'(NSEC-1)) begin
                            y       <= yo;
                            y_valid <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            xin   <= yo;
                            sec   <= sec + SW'(1);
                            state <= MAC;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Per-section history shift on ROUND; flush wipes every section.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSEC; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < NSEC; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else if (state == ROUND) begin
            x2[sec] <= x1[sec];
            x1[sec] <= xin;
            y2[sec] <= y1[sec];
            y1[sec] <= yo;
        end
    end

    // Coefficient bank: writable only while idle, out-of-range addresses dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSEC; s++) begin
                coef[5*s+0] <= DEF_B0;
                coef[5*s+1] <= DEF_B1;
                coef[5*s+2] <= DEF_B2;
                coef[5*s+3] <= DEF_MA1;
                coef[5*s+4] <= DEF_MA2;
            end
        end else if (cfg_we && (state == IDLE) && (int'(cfg_addr) < NCOEF)) begin
            coef[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_iir_cascade_sequencer.sv
// Purpose: scoreboard bench for iir_cascade_sequencer against a plain-arithmetic biquad cascade model.
// Latency: expects each result 6*NSEC edges after its accepting edge.
// Backpressure: predicts x_ready/busy/cfg_ready from its own notion of when the DUT becomes idle.
module tb_iir_cascade_sequencer;
    localparam int NSEC   = 2;
    localparam int DW     = 11;
    localparam int CW     = 12;
    localparam int AW     = $clog2(5*NSEC);
    localparam int NOHAND = 99999;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] x;
    logic                 x_valid;
    logic                 x_ready;
    logic signed [DW-1:0] y;
    logic                 y_valid;
    logic                 flush;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic signed [CW-1:0] cfg_data;
    logic                 cfg_ready;
    logic                 busy;

    iir_cascade_sequencer #(.NSEC(NSEC), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .x_ready(x_ready),
        .y(y), .y_valid(y_valid), .flush(flush), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int y;
        int hs;
        int hand;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  nvec = 0;
    int  nerr = 0;
    int  exp_hold = 0;
    int  idle_at = 0;

    int mc  [5*NSEC];
    int mx1 [NSEC];
    int mx2 [NSEC];
    int my1 [NSEC];
    int my2 [NSEC];

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each section is y = round(b0*x + b1*x1 + b2*x2 + ma1*y1 + ma2*y2, 10 frac bits),
    // rounding half up and keeping only the low 11 bits of the integer result.
    task automatic model_run(input int xin, output int yout);
        int     v;
        int     yo;
        longint sum;
        longint q;
        v = xin;
        for (int s = 0; s < NSEC; s++) begin
            sum = longint'(mc[5*s])   * longint'(v)
                + longint'(mc[5*s+1]) * longint'(mx1[s])
                + longint'(mc[5*s+2]) * longint'(mx2[s])
                + longint'(mc[5*s+3]) * longint'(my1[s])
                + longint'(mc[5*s+4]) * longint'(my2[s]);
            q  = (sum + 64'sd512) >>> 10;
            yo = int'(q & 64'sd2047);
            if (yo >= 1024) yo = yo - 2048;
            mx2[s] = mx1[s];
            mx1[s] = v;
            my2[s] = my1[s];
            my1[s] = yo;
            v = yo;
        end
        yout = v;
    endtask

    task automatic model_clear_hist();
        for (int s = 0; s < NSEC; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NSEC; s++) begin
            mc[5*s+0] = 47;
            mc[5*s+1] = -14;
            mc[5*s+2] = 47;
            mc[5*s+3] = 1544;
            mc[5*s+4] = -881;
        end
        model_clear_hist();
        sb.delete();
        idle_at  = 0;
        exp_hold = 0;
    endtask

    // One cycle of stimulus: drive at the falling edge, check the idle-side outputs, update the model.
    task automatic drive(input bit xv, input int xd, input bit fl, input bit we,
                         input int a, input int d, input int hand);
        bit idle;
        int yexp;
        @(negedge clk);
        x_valid  = xv;
        x        = DW'(xd);
        flush    = fl;
        cfg_we   = we;
        cfg_addr = AW'(a);
        cfg_data = CW'(d);
        #1;
        idle = (cyc >= idle_at);
        chk("busy", busy, int'(!idle));
        chk("cfg_ready", cfg_ready, int'(idle));
        chk("x_ready", x_ready, int'(idle && !fl));
        if (we && idle && (a < 5*NSEC)) mc[a] = d;
        if (fl) begin
            if (!idle) begin
                if (sb.size() > 0) void'(sb.pop_back());
                idle_at = cyc + 1;
            end
            model_clear_hist();
        end else if (xv && idle) begin
            model_run(xd, yexp);
            sb.push_back('{yexp, cyc + 1, hand});
            idle_at = cyc + 1 + 6*NSEC;
        end
    endtask

    task automatic idle_cycle();
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0, NOHAND);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < idle_at) idle_cycle();
    endtask

    task automatic cfg_write(input int a, input int d);
        wait_idle();
        drive(1'b0, 0, 1'b0, 1'b1, a, d, NOHAND);
    endtask

    task automatic random_phase(input int n);
        bit xv, fl, we;
        int xd, a, d;
        for (int i = 0; i < n; i++) begin
            xv = ($urandom_range(0, 2) != 0);
            xd = int'($urandom_range(0, 2047)) - 1024;
            fl = ($urandom_range(0, 49) == 0);
            we = ($urandom_range(0, 7) == 0);
            a  = int'($urandom_range(0, 15));
            d  = int'($urandom_range(0, 4095)) - 2048;
            drive(xv, xd, fl, we, a, d, NOHAND);
        end
    endtask

    // Monitor: every y_valid must match the oldest outstanding prediction; y must hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (y_valid) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL spurious_y_valid: got y_valid=1 y=%0d, expected no result (cycle %0d)", y, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("y_model", y, mon_e.y);
                    chk("latency", cyc - mon_e.hs, 6*NSEC);
                    if (mon_e.hand != NOHAND) chk("y_directed", y, mon_e.hand);
                    exp_hold = mon_e.y;
                end
            end else begin
                chk("y_hold", y, exp_hold);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; x = '0; x_valid = 1'b0; flush = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        #1;
        chk("reset_y", y, 0);
        chk("reset_y_valid", y_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_x_ready", x_ready, 1);
        chk("reset_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Defaults, zero history, two sections: 512 -> 24 after section 0 -> 1 after section 1.
        drive(1'b1, 512, 1'b0, 1'b0, 0, 0, 1);
        // x_valid held high: each next sample must be taken in its predecessor's y_valid cycle.
        for (int i = 0; i < 40; i++) drive(1'b1, int'($urandom_range(0, 2047)) - 1024, 1'b0, 1'b0, 0, 0, NOHAND);

        // Section 1 as identity (b0=1.0), so y shows section 0 alone: 512 -> 24, then 0 -> 29.
        cfg_write(5, 1024);
        for (int k = 6; k < 10; k++) cfg_write(k, 0);
        wait_idle();
        drive(1'b0, 0, 1'b1, 1'b0, 0, 0, NOHAND);
        drive(1'b1, 512, 1'b0, 1'b0, 0, 0, 24);
        wait_idle();
        drive(1'b1, 0, 1'b0, 1'b0, 0, 0, 29);

        // Both sections identity: -300 passes through unchanged.
        cfg_write(0, 1024);
        for (int k = 1; k < 5; k++) cfg_write(k, 0);
        wait_idle();
        drive(1'b1, -300, 1'b0, 1'b0, 0, 0, -300);
        // Same again with b0 written on the accepting edge itself.
        cfg_write(0, 0);
        wait_idle();
        drive(1'b1, -300, 1'b0, 1'b1, 0, 1024, -300);

        // Wrap: -2048 * -1024 = 2^21, low 21 bits zero -> 0; a write while busy must not land.
        cfg_write(0, -2048);
        wait_idle();
        drive(1'b1, -1024, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b0, 0, 1'b0, 1'b1, 0, 5, NOHAND);
        wait_idle();
        drive(1'b1, -1024, 1'b0, 1'b0, 0, 0, 0);

        // Asynchronous reset in the middle of section-0 MAC.
        wait_idle();
        drive(1'b1, 300, 1'b0, 1'b0, 0, 0, NOHAND);
        idle_cycle();
        idle_cycle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", y, 0);
        chk("async_rst_y_valid", y_valid, 0);
        chk("async_rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 512, 1'b0, 1'b0, 0, 0, 1);

        // Flush together with x_valid while idle: nothing accepted.
        wait_idle();
        drive(1'b1, 333, 1'b1, 1'b0, 0, 0, NOHAND);
        // Flush at section-1 tap 2; next impulse must match the from-reset answer.
        drive(1'b1, 700, 1'b0, 1'b0, 0, 0, NOHAND);
        repeat (8) idle_cycle();
        drive(1'b0, 0, 1'b1, 1'b0, 0, 0, NOHAND);
        drive(1'b1, 512, 1'b0, 1'b0, 0, 0, 1);

        random_phase(700);

        wait_idle();
        repeat (3) idle_cycle();
        chk("drain_outstanding", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/iir_cascade_sequencer.md
Name: iir_cascade_sequencer

Overview:
- Time-multiplexed controller and datapath for a cascade of NSEC second-order IIR sections.
- One shared 11x12 signed multiplier and one 23-bit accumulator serve all sections.
- Holds the per-section history (x1, x2, y1, y2) and a writable coefficient bank.
- Sits between the sensor sample stream and the spike-detection back end, replacing one hardwired section instance per stage.

Parameters:
- NSEC, 2, number of cascaded biquad sections (1..8).
- DW, 11, sample width, signed.
- CW, 12, coefficient width, signed, 10 fractional bits.
- AW, $clog2(5*NSEC), coefficient address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  DW  input sample, signed.
- x_valid  in  1  input sample valid.
- x_ready  out  1  sample accept; handshake occurs when x_valid && x_ready at a clock edge.
- y  out  DW  filtered output of the last section, signed, registered.
- y_valid  out  1  one-cycle pulse, y is new.
- flush  in  1  synchronous clear of all section history; aborts any computation in progress.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  AW  coefficient address: section*5 + k, with k = 0:b0, 1:b1, 2:b2, 3:ma1, 4:ma2.
- cfg_data  in  CW  coefficient value, signed.
- cfg_ready  out  1  high only in IDLE; writes with cfg_ready=0 are ignored.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; y=0; y_valid=0; all history registers 0.
  - Every section's coefficients load the defaults b0=47, b1=-14, b2=47, ma1=1544, ma2=-881.
- x_ready = (state==IDLE) && !flush, combinational. cfg_ready = (state==IDLE).
- FSM states and transitions:
  - IDLE: on handshake, latch x as the section-0 input, set sec=0, tap=0, go to MAC.
  - MAC: 5 cycles, tap 0..4. The accumulator adds one 23-bit product per cycle:
    - tap 0: b0*xin
    - tap 1: b1*x1
    - tap 2: b2*x2
    - tap 3: ma1*y1
    - tap 4: ma2*y2
    - The accumulator clears at tap 0. After tap 4, go to ROUND.
  - ROUND, 1 cycle:
    - r = acc[20:0] + 512 (21-bit, wrapping); yo = r[20:10].
    - No saturation. Bits 22:21 of acc are discarded, and the sum wraps modulo 2^23.
    - Update section sec: x2<=x1, x1<=xin, y2<=y1, y1<=yo.
    - If sec<NSEC-1: xin<=yo, sec<=sec+1, go to MAC.
    - Otherwise: y<=yo, y_valid<=1, go to IDLE.
- ma1 and ma2 are the negated feedback coefficients, so the datapath only adds.
- Latency: for a handshake at edge E, y_valid is high in the cycle after edge E+6*NSEC.
  - y_valid lasts exactly one cycle; y holds its value until the next result.
  - x_ready is high in that same cycle, so peak throughput is one sample per 6*NSEC+1 cycles.
- Flush:
  - In any state: the FSM goes to IDLE at the next edge and all history is cleared.
  - The accumulator and the in-flight sample are discarded; no y_valid is produced for it.
  - y keeps its last value; coefficients are unchanged.
- cfg_we in IDLE: the coefficient is written at that edge.
  - cfg_addr >= 5*NSEC is ignored.
  - When a write and a handshake occur at the same edge, the new coefficient applies to that sample, because MAC begins in the next cycle.
- flush and x_valid together in IDLE: flush wins and no sample is accepted.
- Reset mid-operation: as reset; no y_valid is emitted afterwards for the aborted sample.

Test Plan:
- NSEC=1, default coefficients: x=512 then x=0. Required y = 24, then 29. Each y_valid arrives 7 cycles after its handshake edge.
- NSEC=2, defaults: handshake at edge E.
  - x_ready stays low and busy stays high for cycles E+1..E+12.
  - y_valid pulses exactly one cycle, after edge E+12.
  - x_valid held high throughout: the second sample is accepted in the y_valid cycle.
- NSEC=1, write b0=1024 and b1=b2=ma1=ma2=0 while idle, then x=-300. Required: y=-300. Repeating the test with the b0 write at the same edge as the handshake gives the same result.
- NSEC=2, assert flush at MAC tap 2 of section 1. Required:
  - No y_valid for that sample.
  - IDLE next cycle, with y unchanged.
  - The next sample x=512 yields the same output as from reset.
- Pull rst_n low mid-MAC, asynchronously between edges. Required:
  - y=0, y_valid=0 and busy=0 immediately.
  - Coefficients read back as defaults: an impulse x=512 reproduces y=24 at NSEC=1.
- Overflow wrap, NSEC=1: write b0=-2048 and the others 0, then x=-1024. acc=2097152, so acc[20:0]=0, and the required y is 0. A cfg_we issued while busy is ignored.
